serial_code_lock: RTL and testbench
===================================

# serial_code_lock

Parametrised serial combination lock: the next generation of the six-state, fixed-code accepter. It collects a user code one bit per strobe, compares it against a stored code of CODE_LEN bits, and opens on a match. It counts failed attempts and enforces a timed lockout. While open, the stored code can be reprogrammed. It sits between the debounced keypad/switch front end and the door-actuator and indicator logic.

## Interface
- CODE_LEN, 4: code length in bits (≥2).
- DEFAULT_CODE, 4'b1011: stored code after reset; first-entered digit is the MSB.
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout (≥1).
- LOCKOUT_CYCLES, 16: lockout duration in clock cycles (≥1).
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- digitValid  in  1  one-cycle strobe; nextDigit is valid this cycle.
- nextDigit  in  1  entered digit.
- program  in  1  mode select, sampled only in OPEN with digitValid.
- clear  in  1  synchronous abort of a partial entry; has priority over digitValid.
- accept  out  1  one-cycle pulse on a correct code.
- open  out  1  lock open (OPEN or PROGRAM state).
- locked  out  1  high throughout LOCKOUT.
- progDone  out  1  one-cycle pulse when a new code is stored.
- position  out  $clog2(CODE_LEN+1)  digits collected in the current entry.
- failCount  out  $clog2(MAX_FAILS+1)  consecutive failures.

## Operation
- States: ENTER, OPEN, PROGRAM, LOCKOUT.
- Reset values:
  - State is ENTER.
  - Stored code is DEFAULT_CODE.
  - Shift register, position, failCount, lockout counter, accept, open, locked and progDone are all 0.
- ENTER:
  - On each digitValid, shift nextDigit into the entry register LSB and increment position.
  - On the CODE_LEN-th digit, compare {entry[CODE_LEN-2:0], nextDigit} with the stored code and reset position to 0.
  - Match: go to OPEN, pulse accept, clear failCount.
  - Mismatch with failCount+1 < MAX_FAILS: stay in ENTER and increment failCount.
  - Mismatch with failCount+1 == MAX_FAILS: go to LOCKOUT, load the counter with LOCKOUT_CYCLES-1, and set failCount to MAX_FAILS.
- OPEN:
  - digitValid with program=1: go to PROGRAM; that digit is the first new-code digit (position=1).
  - digitValid with program=0: relock to ENTER; the digit is discarded.
- PROGRAM:
  - Collect digits as in ENTER; program is ignored after entry.
  - On the CODE_LEN-th digit, write the new code to the stored register, pulse progDone, go to ENTER, position=0.
- LOCKOUT:
  - digitValid and clear are ignored; position holds at 0.
  - The counter decrements each cycle.
  - On the cycle it reads 0, go to ENTER and clear failCount.
- clear:
  - ENTER: position=0 and the partial entry is discarded; failCount is unchanged.
  - PROGRAM: return to OPEN; stored code unchanged; position=0.
  - OPEN and LOCKOUT: no effect.
- Wrap-around and saturation: position never exceeds CODE_LEN-1 at a clock edge; failCount saturates at MAX_FAILS.

## Timing
- All outputs are registered and change only on a rising clock edge or on reset assertion.
- Accept latency: digitValid with the final digit sampled at edge k → accept and open high after edge k. accept drops at edge k+1; open holds.
- progDone follows the same pattern: high for exactly one cycle after the edge that samples the final programmed digit. open falls at that same edge.
- Lockout length: locked rises at edge k (the failing edge) and stays high for exactly LOCKOUT_CYCLES cycles, falling at edge k+LOCKOUT_CYCLES.
- Back-to-back entries: digitValid may be high on consecutive cycles with no bubbles; the first digit of the next code may arrive on the cycle after the comparing edge.
- Reset mid-operation: asserting reset in any state returns all state to its reset values immediately, including the stored code reverting to DEFAULT_CODE. Deassertion is assumed synchronous to clock upstream.

## Test plan
- Correct code: defaults, digits 1,0,1,1 on consecutive cycles → accept high for 1 cycle after the 4th edge; open=1; failCount=0.
- Lockout: three entries of 0,0,0,0 → failCount 1,2 after the first two attempts; after the 3rd, locked=1 for exactly 16 cycles. Digits 1,0,1,1 during lockout → ignored, no accept. After lockout, failCount=0.
- Reprogram: open the lock; program=1 with digits 0,1,1,0 → progDone pulse, open=0. Then 1,0,1,1 → fail (failCount=1). Then 0,1,1,0 → accept.
- Clear: enter 1,0, clear, then 1,0,1,1 → position 0 after clear, accept on the 4th digit. clear and digitValid in the same cycle → digit dropped.
- Relock: in OPEN, digitValid with program=0 → open=0, state ENTER, position=0.
- Async reset: assert reset mid-PROGRAM after 2 digits → all outputs 0 immediately. Then 1,0,1,1 → accept (default code restored).

Source files
------------

// File: rtl/serial_code_lock.sv
// serial_code_lock: parametrised serial combination lock with
// failure counting, timed lockout and in-place code reprogramming.
module serial_code_lock #(
    parameter int unsigned          CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0]  DEFAULT_CODE   = 4'b1011,
    parameter int unsigned          MAX_FAILS      = 3,
    parameter int unsigned          LOCKOUT_CYCLES = 16
) (
    input  logic                               clock_i,
    input  logic                               reset_ni,
    input  logic                               digitValid_i,
    input  logic                               nextDigit_i,
    input  logic                               program_i,
    input  logic                               clear_i,
    output logic                               accept_o,
    output logic                               open_o,
    output logic                               locked_o,
    output logic                               progDone_o,
    output logic [$clog2(CODE_LEN+1)-1:0]      position_o,
    output logic [$clog2(MAX_FAILS+1)-1:0]     failCount_o
);

    localparam int unsigned PW = $clog2(CODE_LEN + 1);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned LW =
        (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_ENTER   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_PROGRAM = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CODE_LEN-1:0]   code_q, code_d;
    // Only CODE_LEN-1 digits need holding; the last one arrives live.
    logic [CODE_LEN-2:0]   entry_q, entry_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [FW-1:0]         fail_q, fail_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic                  accept_q, accept_d;
    logic                  open_q, open_d;
    logic                  locked_q, locked_d;
    logic                  pdone_q, pdone_d;

    logic [CODE_LEN-1:0]   word;
    logic                  last_digit;
    logic                  last_fail;

    assign word       = {entry_q, nextDigit_i};
    assign last_digit = (pos_q == PW'(CODE_LEN - 1));
    assign last_fail  = (fail_q >= FW'(MAX_FAILS - 1));

    // State and datapath registers, all cleared by the async reset.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_ENTER;
            code_q   <= DEFAULT_CODE;
            entry_q  <= '0;
            pos_q    <= '0;
            fail_q   <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            open_q   <= 1'b0;
            locked_q <= 1'b0;
            pdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            entry_q  <= entry_d;
            pos_q    <= pos_d;
            fail_q   <= fail_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            open_q   <= open_d;
            locked_q <= locked_d;
            pdone_q  <= pdone_d;
        end
    end

    // Next-state logic; status outputs are derived from the next state
    // so they leave the register bank together with it.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        entry_d  = entry_q;
        pos_d    = pos_q;
        fail_d   = fail_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        pdone_d  = 1'b0;

        unique case (state_q)
            ST_ENTER: begin
                if (clear_i) begin
                    pos_d   = '0;
                    entry_d = '0;
                end else if (digitValid_i) begin
                    entry_d = word[CODE_LEN-2:0];
                    if (last_digit) begin
                        pos_d = '0;
                        if (word == code_q) begin
                            state_d  = ST_OPEN;
                            accept_d = 1'b1;
                            fail_d   = '0;
                        end else if (!last_fail) begin
                            fail_d = fail_q + FW'(1);
                        end else begin
                            state_d = ST_LOCKOUT;
                            cnt_d   = LW'(LOCKOUT_CYCLES - 1);
                            fail_d  = FW'(MAX_FAILS);
                        end
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
            end

            ST_OPEN: begin
                if (digitValid_i) begin
                    if (program_i) begin
                        state_d = ST_PROGRAM;
                        entry_d = word[CODE_LEN-2:0];
                        pos_d   = PW'(1);
                    end else begin
                        state_d = ST_ENTER;
                        pos_d   = '0;
                    end
                end
            end

            ST_PROGRAM: begin
                if (clear_i) begin
                    state_d = ST_OPEN;
                    pos_d   = '0;
                end else if (digitValid_i) begin
                    entry_d = word[CODE_LEN-2:0];
                    if (last_digit) begin
                        code_d  = word;
                        pdone_d = 1'b1;
                        state_d = ST_ENTER;
                        pos_d   = '0;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                pos_d = '0;
                if (cnt_q == '0) begin
                    state_d = ST_ENTER;
                    fail_d  = '0;
                end else begin
                    cnt_d = cnt_q - LW'(1);
                end
            end

            default: begin
                state_d = ST_ENTER;
            end
        endcase

        open_d   = (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
        locked_d = (state_d == ST_LOCKOUT);
    end

    assign accept_o    = accept_q;
    assign open_o      = open_q;
    assign locked_o    = locked_q;
    assign progDone_o  = pdone_q;
    assign position_o  = pos_q;
    assign failCount_o = fail_q;

endmodule

// File: tb/tb_serial_code_lock.sv
// tb_serial_code_lock: directed vector table, reset corner case and
// random stimulus against a queue-based reference model.
module tb_serial_code_lock;

    localparam int CL = 4;
    localparam int MF = 3;
    localparam int LC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0, nd = 1'b0, pg = 1'b0, cl = 1'b0;
    logic       acc, opn, lck, pdn;
    logic [2:0] pos;
    logic [1:0] fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_code_lock dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .digitValid_i (dv),
        .nextDigit_i  (nd),
        .program_i    (pg),
        .clear_i      (cl),
        .accept_o     (acc),
        .open_o       (opn),
        .locked_o     (lck),
        .progDone_o   (pdn),
        .position_o   (pos),
        .failCount_o  (fcnt)
    );

    typedef struct {
        logic       v, d, p, c;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic d, logic p, logic c,
                                logic a, logic o, logic l, logic q,
                                int ps, int fl);
        vec_t t;
        t.v = v; t.d = d; t.p = p; t.c = c;
        t.exp = {a, o, l, q, 3'(ps), 2'(fl)};
        tbl.push_back(t);
    endfunction

    function automatic logic [8:0] outs();
        return {acc, opn, lck, pdn, pos, fcnt};
    endfunction

    task automatic check(string nm, logic [8:0] got, logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {acc,open,lock,pd,pos,fail}=%b want %b",
                     nm, got, exp);
        end
    endtask

    task automatic run(string nm, vec_t t);
        @(negedge clk);
        dv = t.v; nd = t.d; pg = t.p; cl = t.c;
        @(posedge clk);
        #1;
        check(nm, outs(), t.exp);
    endtask

    // Enter a 4-digit code (MSB first) from ENTER, expecting positions
    // 1..3 and a final row described by the caller.
    function automatic void add_code(logic [3:0] code, int fl,
                                     logic a, logic o, logic l,
                                     int fl_end);
        for (int i = 0; i < 3; i++)
            add(1, code[3-i], 0, 0, 0, 0, 0, 0, i + 1, fl);
        add(1, code[0], 0, 0, a, o, l, 0, 0, fl_end);
    endfunction

    // Reference model: digits kept in a queue, code as an integer,
    // lockout tracked as remaining high cycles.
    localparam int M_ENTER = 0, M_OPEN = 1, M_PROG = 2, M_LOCK = 3;
    int m_mode, m_code, m_fail, m_rem;
    bit m_acc, m_pd;
    bit m_q[$];

    function automatic int fold();
        int v = 0;
        foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
        return v;
    endfunction

    function automatic void m_reset();
        m_mode = M_ENTER; m_code = 'b1011; m_fail = 0; m_rem = 0;
        m_acc = 0; m_pd = 0; m_q.delete();
    endfunction

    function automatic void m_step(bit v, bit d, bit p, bit c);
        int val;
        m_acc = 0; m_pd = 0;
        case (m_mode)
            M_ENTER: if (c) m_q.delete();
                else if (v) begin
                    m_q.push_back(d);
                    if (m_q.size() == CL) begin
                        val = fold(); m_q.delete();
                        if (val == m_code) begin
                            m_mode = M_OPEN; m_acc = 1; m_fail = 0;
                        end else begin
                            m_fail++;
                            if (m_fail == MF) begin
                                m_mode = M_LOCK; m_rem = LC;
                            end
                        end
                    end
                end
            M_OPEN: if (v) begin
                    m_q.delete();
                    if (p) begin m_mode = M_PROG; m_q.push_back(d); end
                    else m_mode = M_ENTER;
                end
            M_PROG: if (c) begin m_mode = M_OPEN; m_q.delete(); end
                else if (v) begin
                    m_q.push_back(d);
                    if (m_q.size() == CL) begin
                        m_code = fold(); m_pd = 1;
                        m_mode = M_ENTER; m_q.delete();
                    end
                end
            default: begin
                m_rem--;
                if (m_rem == 0) begin m_mode = M_ENTER; m_fail = 0; end
            end
        endcase
    endfunction

    function automatic logic [8:0] m_outs();
        return {m_acc, m_mode == M_OPEN || m_mode == M_PROG,
                m_mode == M_LOCK, m_pd, 3'(m_q.size()), 2'(m_fail)};
    endfunction

    initial begin
        vec_t t;
        logic [8:0] zero;
        zero = '0;

        // correct default code, then relock
        add_code(4'b1011, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // three wrong entries into lockout
        add_code(4'b0000, 0, 0, 0, 0, 1);
        add_code(4'b0000, 1, 0, 0, 0, 2);
        add_code(4'b0000, 2, 0, 0, 1, 3);
        for (int i = 0; i < LC - 1; i++) begin
            t.d = 1'b0;
            if (i == 0 || i == 2 || i == 3) t.d = 1'b1;
            add(i < 4, t.d, 0, i == 5, 0, 0, 1, 0, 0, 3);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reprogram to 0110
        add_code(4'b1011, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0, 0, 2, 0);
        add(1, 1, 1, 0, 0, 1, 0, 0, 3, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_code(4'b1011, 0, 0, 0, 0, 1);
        add_code(4'b0110, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // clear during entry, clear beating a digit
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_code(4'b0110, 0, 1, 1, 0, 0);
        // clear ignored in OPEN; clear in PROGRAM returns to OPEN
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_code(4'b0110, 0, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 2, 0);

        repeat (2) @(negedge clk);
        check("reset_state", outs(), zero);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

        // async reset mid-PROGRAM after two digits
        @(negedge clk);
        dv = 1'b0; pg = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), zero);
        @(negedge clk);
        rst_n = 1'b1;
        tbl.delete();
        add_code(4'b1011, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        foreach (tbl[i]) run($sformatf("post_rst%0d", i), tbl[i]);

        // random stimulus vs reference model
        @(negedge clk);
        rst_n = 1'b0;
        dv = 0; nd = 0; pg = 0; cl = 0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int bi;
            @(negedge clk);
            dv = ($urandom_range(0, 2) != 0);
            pg = $urandom_range(0, 1);
            cl = ($urandom_range(0, 15) == 0);
            bi = CL - 1 - m_q.size();
            if (m_mode == M_ENTER && $urandom_range(0, 3) != 0 && bi >= 0)
                nd = m_code[bi];
            else
                nd = $urandom_range(0, 1);
            @(posedge clk);
            m_step(dv, nd, pg, cl);
            #1;
            check($sformatf("rand%0d", n), outs(), m_outs());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
